// File: rtl/dsp_div_unsigned_seq_if.sv
// dsp_div_unsigned_seq_if
//   Handshake/data bundle for the sequential unsigned divider.
//   master : requester side (drives start/dividend/divisor, observes results)
//   slave  : divider side
//   start        request, sampled only while busy=0
//   dividend     DIVIDEND_W-bit operand, captured on accepted start
//   divisor      DIVISOR_W-bit operand, captured on accepted start
//   busy         high while iterating
//   done         one-cycle result-valid pulse
//   quotient     DIVIDEND_W-bit result, held until the next done
//   remainder    DIVISOR_W-bit result, held until the next done
//   div_by_zero  set with done when the divisor was 0
//   qfit_err     set with done when the quotient does not fit A_W bits
interface dsp_div_unsigned_seq_if #(
  parameter int DIVIDEND_W = 38,
  parameter int DIVISOR_W  = 18
);
  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;
  logic                  qfit_err;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, qfit_err
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, qfit_err
  );
endinterface

// File: rtl/dsp_div_unsigned_seq.sv
// dsp_div_unsigned_seq
//   Sequential radix-2 restoring unsigned divider, one quotient bit per cycle
//   MSB first. Defaults invert the 20x18->38 multiplier, so P / B recovers A.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  dsp_div_unsigned_seq_if.slave (start/busy/done handshake, operands,
//          quotient, remainder, div_by_zero, qfit_err)
//   Optional feature: define DSP_DIV_QFIT_CHECK_EN to build the quotient-fit
//   check (qfit_err = quotient >= 2**A_W, never with div_by_zero). Without it
//   qfit_err is constant 0.
module dsp_div_unsigned_seq #(
  parameter int DIVIDEND_W = 38,
  parameter int DIVISOR_W  = 18,
  parameter int A_W        = 20
) (
  input logic                   clk,
  input logic                   rst,
  dsp_div_unsigned_seq_if.slave bus
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDEND_W - 1);

  if (A_W < 1 || A_W >= DIVIDEND_W) begin : g_bad_a_w
    $error("A_W must lie in 1..DIVIDEND_W-1");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_q, state_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;   // dividend shifting out, quotient shifting in
  logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;   // partial remainder
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  rmd_q, rmd_d;
  logic                  dbz_q, dbz_d;
  logic                  qfit_q, qfit_d;

  logic [DIVISOR_W:0]    trial;
  logic                  ge;
  logic [DIVISOR_W-1:0]  rem_nxt;
  logic [DIVIDEND_W-1:0] dvd_nxt;

  // One restoring step. Since rem_q < divisor, trial < 2*divisor and the
  // difference always fits back into DIVISOR_W bits.
  always_comb begin
    trial   = {rem_q, dvd_q[DIVIDEND_W-1]};
    ge      = (trial >= {1'b0, dsr_q});
    rem_nxt = ge ? DIVISOR_W'(trial - {1'b0, dsr_q}) : trial[DIVISOR_W-1:0];
    dvd_nxt = {dvd_q[DIVIDEND_W-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    qfit_d  = qfit_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          dvd_d = bus.dividend;
          dsr_d = bus.divisor;
          rem_d = '0;
          cnt_d = '0;
          if (bus.divisor == '0) begin
            // Zero divisor skips iteration and reports in the next cycle.
            state_d = DONE;
            quo_d   = '1;
            rmd_d   = '0;
            dbz_d   = 1'b1;
            qfit_d  = 1'b0;
          end else begin
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        dvd_d = dvd_nxt;
        rem_d = rem_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          // Results are taken straight from the final step so that DONE
          // is the cycle right after the last iteration.
          state_d = DONE;
          quo_d   = dvd_nxt;
          rmd_d   = rem_nxt;
          dbz_d   = 1'b0;
`ifdef DSP_DIV_QFIT_CHECK_EN
          qfit_d  = |dvd_nxt[DIVIDEND_W-1:A_W];
`else
          qfit_d  = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
      qfit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
      qfit_q  <= qfit_d;
    end
  end

  assign bus.busy        = (state_q == CALC);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rmd_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.qfit_err    = qfit_q;

endmodule

// File: tb/tb_dsp_div_unsigned_seq.sv
// tb_dsp_div_unsigned_seq
//   Directed vector table for the sequential divider plus hand-written
//   sequences: back-to-back random pairs, ignored start while busy, and
//   reset in the middle of a computation.
module tb_dsp_div_unsigned_seq;

  localparam int DW = 38;
  localparam int SW = 18;
`ifdef DSP_DIV_QFIT_CHECK_EN
  localparam bit QFIT_ON = 1'b1;
`else
  localparam bit QFIT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dsp_div_unsigned_seq_if #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) bus ();

  dsp_div_unsigned_seq #(.DIVIDEND_W(DW), .DIVISOR_W(SW), .A_W(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] q;
    logic [63:0] r;
    bit          dbz;
    bit          qfit;
    int          cyc;
    int          busy;
  } vec_t;

  // Caller must be at a negedge. Returns at the negedge where done is seen
  // (so a following call starts in the done cycle). cycles = -1 on timeout.
  task automatic run_div(input logic [63:0] a, input logic [63:0] b,
                         input int pulse_at, input logic [63:0] pa, input logic [63:0] pb,
                         output logic [63:0] q, output logic [63:0] r,
                         output bit dbz, output bit qfit,
                         output int cycles, output int busy_cnt);
    bus.start    = 1'b1;
    bus.dividend = a[DW-1:0];
    bus.divisor  = b[SW-1:0];
    cycles   = 0;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      cycles++;
      if (cycles == pulse_at) begin
        bus.start    = 1'b1;
        bus.dividend = pa[DW-1:0];
        bus.divisor  = pb[SW-1:0];
      end else begin
        bus.start = 1'b0;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) break;
      if (cycles > 100) begin
        cycles = -1;
        break;
      end
    end
    bus.start = 1'b0;
    q    = 64'(bus.quotient);
    r    = 64'(bus.remainder);
    dbz  = bus.div_by_zero;
    qfit = bus.qfit_err;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[10];
    logic [63:0] q, r, a, b, prev_q;
    bit          dbz, qfit;
    int          cyc, bcnt, done_seen;

    vecs[0] = '{64'd10,           64'd2,      64'd5,            64'd0,      0, 0, 39, 38};
    vecs[1] = '{64'd274876596225, 64'd262143, 64'd1048575,      64'd0,      0, 0, 39, 38};
    vecs[2] = '{64'd100,          64'd7,      64'd14,           64'd2,      0, 0, 39, 38};
    vecs[3] = '{64'd12345,        64'd0,      64'd274877906943, 64'd0,      1, 0, 1,  0};
    vecs[4] = '{64'd137438953472, 64'd1,      64'd137438953472, 64'd0,      0, 1, 39, 38};
    vecs[5] = '{64'd0,            64'd5,      64'd0,            64'd0,      0, 0, 39, 38};
    vecs[6] = '{64'd274877906943, 64'd262143, 64'd1048580,      64'd3,      0, 1, 39, 38};
    vecs[7] = '{64'd7,            64'd9,      64'd0,            64'd7,      0, 0, 39, 38};
    vecs[8] = '{64'd1048576,      64'd1,      64'd1048576,      64'd0,      0, 1, 39, 38};
    vecs[9] = '{64'd1048575,      64'd1,      64'd1048575,      64'd0,      0, 0, 39, 38};

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_q",    64'(bus.quotient), 64'd0);
    chk("rst_r",    64'(bus.remainder), 64'd0);
    chk("rst_dbz",  64'(bus.div_by_zero), 64'd0);
    chk("rst_qfit", 64'(bus.qfit_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table, each vector followed by an idle cycle
    for (int i = 0; i < 10; i++) begin
      run_div(vecs[i].a, vecs[i].b, 0, 64'd0, 64'd0, q, r, dbz, qfit, cyc, bcnt);
      chk($sformatf("v%0d_q", i),    q, vecs[i].q);
      chk($sformatf("v%0d_r", i),    r, vecs[i].r);
      chk($sformatf("v%0d_dbz", i),  64'(dbz), 64'(vecs[i].dbz));
      chk($sformatf("v%0d_qfit", i), 64'(qfit), 64'(vecs[i].qfit & QFIT_ON));
      chk($sformatf("v%0d_cyc", i),  64'(cyc), 64'(vecs[i].cyc));
      chk($sformatf("v%0d_busy", i), 64'(bcnt), 64'(vecs[i].busy));
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), 64'(bus.done), 64'd0);
      chk($sformatf("v%0d_hold_q", i), 64'(bus.quotient), vecs[i].q);
    end

    // 100/7 then 32 random pairs, each started in the previous done cycle
    run_div(64'd100, 64'd7, 0, 64'd0, 64'd0, q, r, dbz, qfit, cyc, bcnt);
    chk("b2b_first_q", q, 64'd14);
    chk("b2b_first_r", r, 64'd2);
    prev_q = 64'd14;
    for (int k = 0; k < 32; k++) begin
      a = {$urandom(), $urandom()} & ((64'd1 << DW) - 64'd1);
      b = 64'($urandom_range(262143, 1));
      run_div(a, b, 0, 64'd0, 64'd0, q, r, dbz, qfit, cyc, bcnt);
      chk($sformatf("rnd%0d_inv", k), q * b + r, a);
      chk($sformatf("rnd%0d_rlt", k), 64'(r < b), 64'd1);
      chk($sformatf("rnd%0d_q", k),   q, a / b);
      chk($sformatf("rnd%0d_cyc", k), 64'(cyc), 64'd39);
      prev_q = a / b;
    end
    @(negedge clk);

    // 9/3 pulsed while busy with 1000/3 must be ignored
    run_div(64'd1000, 64'd3, 10, 64'd9, 64'd3, q, r, dbz, qfit, cyc, bcnt);
    chk("ign_q",   q, 64'd333);
    chk("ign_r",   r, 64'd1);
    chk("ign_cyc", 64'(cyc), 64'd39);
    @(negedge clk);

    // Reset in mid-calculation discards the operation
    bus.start    = 1'b1;
    bus.dividend = DW'(1000);
    bus.divisor  = SW'(3);
    @(negedge clk);
    bus.start = 1'b0;
    done_seen = 0;
    for (int c = 2; c <= 20; c++) begin
      @(negedge clk);
      if (c == 10) begin
        bus.start    = 1'b1;
        bus.dividend = DW'(9);
      end else begin
        bus.start = 1'b0;
      end
      if (c == 5) chk("mid_hold_q", 64'(bus.quotient), 64'd333);
      if (bus.done) done_seen++;
    end
    chk("pre_rst_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_done", 64'(bus.done), 64'd0);
    chk("arst_q",    64'(bus.quotient), 64'd0);
    chk("arst_r",    64'(bus.remainder), 64'd0);
    chk("arst_dbz",  64'(bus.div_by_zero), 64'd0);
    chk("arst_qfit", 64'(bus.qfit_err), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    chk("no_done_after_rst", 64'(done_seen), 64'd0);
    run_div(64'd9, 64'd3, 0, 64'd0, 64'd0, q, r, dbz, qfit, cyc, bcnt);
    chk("post_rst_q",   q, 64'd3);
    chk("post_rst_r",   r, 64'd0);
    chk("post_rst_cyc", 64'(cyc), 64'd39);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dsp_div_unsigned_seq.md
# dsp_div_unsigned_seq

Sequential unsigned radix-2 restoring divider: the inverse of the combinational unsigned multiplier in the DSP design set. It takes a DIVIDEND_W-bit product and a DIVISOR_W-bit factor and returns quotient and remainder over DIVIDEND_W iteration cycles. A start/busy/done handshake controls it. Its defaults match the 20x18→38 multiplier, so P / B recovers A.

## Interface
- DIVIDEND_W, 38, dividend and quotient width
- DIVISOR_W, 18, divisor and remainder width
- A_W, 20, quotient-fit width checked when the fit-check feature is compiled in
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only when busy=0
- dividend  input  DIVIDEND_W  captured on accepted start
- divisor  input  DIVISOR_W  captured on accepted start
- busy  output  1  high while iterating
- done  output  1  single-cycle result-valid pulse
- quotient  output  DIVIDEND_W  result, held until the next done
- remainder  output  DIVISOR_W  result, held until the next done
- div_by_zero  output  1  set with done when divisor was 0
- qfit_err  output  1  set with done when quotient ≥ 2^A_W (feature-dependent)

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE.
- IDLE or DONE, start=1:
  - Capture operands into working registers; clear partial remainder; clear count.
  - If divisor≠0, go to CALC. If divisor=0, go to DONE directly.
- IDLE or DONE, start=0: go to / stay in IDLE.
- CALC, one quotient bit per cycle, MSB first:
  - Form trial = {rem, next dividend bit}. Width is DIVISOR_W+1 with no truncation.
  - If trial ≥ divisor: rem = trial − divisor, q bit = 1. Otherwise rem = trial, q bit = 0.
  - After DIVIDEND_W iterations, go to DONE.
- DONE:
  - On entry, register quotient, remainder and flags; done=1 for that one cycle.
  - Divide-by-zero result: quotient = all ones, remainder = 0, div_by_zero = 1.
- start while busy=1 is ignored; no queuing, and operands are not recaptured.
- start in the DONE cycle is accepted, giving back-to-back operation.
- quotient, remainder and flags hold their values through a subsequent computation until its DONE.
- Invariant for nonzero divisor: dividend = quotient*divisor + remainder, and remainder < divisor.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, qfit_err=0, state IDLE. Working registers are cleared.
- Start accepted at edge E0, nonzero divisor:
  - busy=1 from E0 through E0+DIVIDEND_W.
  - done=1 and results valid after edge E0+DIVIDEND_W+1; 39 cycles at defaults. busy=0 in the done cycle.
- Start accepted at E0, divisor=0: done=1 after E0+1; busy never asserts.
- Throughput, back-to-back: one result every DIVIDEND_W+1 cycles.
- rst asserted at any point, including mid-CALC or in the done cycle: all outputs go to reset values immediately. The in-flight operation is discarded. The first edge after deassertion behaves as IDLE.
- done is never high for two consecutive cycles unless a zero-divisor start is accepted in the done cycle.

## Configuration
- Macro DSP_DIV_QFIT_CHECK_EN.
- Defined: qfit_err = (quotient ≥ 2^A_W) and ¬div_by_zero. It is registered with done and held with the results. This flags products that are not a valid A_W-bit multiplier operand.
- Undefined: qfit_err is tied 0 and no comparison logic is built. All other behaviour is identical.

## Test plan
- Divide 10 by 2 → quotient=5, remainder=0, div_by_zero=0. done arrives exactly 39 cycles after the start edge, with busy high for 38 cycles.
- Divide 274876596225 by 262143 (max 20x18 product) → quotient=1048575, remainder=0, qfit_err=0.
- Divide 100 by 7 → quotient=14, remainder=2. Follow with 32 random unsigned pairs back-to-back (start in the done cycle); each must satisfy dividend = q*divisor + r with r < divisor.
- Divide 12345 by 0 → done after 1 cycle, quotient=2^38−1, remainder=0, div_by_zero=1, busy never high.
- Divide 137438953472 by 1 → quotient=137438953472, remainder=0. qfit_err=1 with DSP_DIV_QFIT_CHECK_EN, 0 without.
- Start 1000/3, pulse start with 9/3 at cycle 10, assert rst at cycle 20, release, then start 9/3:
  - The pulse at cycle 10 is ignored.
  - rst zeroes all outputs and no done appears for 1000/3.
  - The post-reset 9/3 gives quotient=3, remainder=0 after 39 cycles.
